sevenseg_scan_driver: RTL and testbench
=======================================

// Module: sevenseg_scan_driver
// PURPOSE
//   Time-multiplexed driver for NUM_DIGITS common-segment 7-segment digits.
//   Takes a packed hex value and refreshes one digit per refresh tick.
//   Drives a shared segment bus plus a one-hot digit enable.
//   Sits between a value producer (counter/ALU result) and the board display pins.
//   Full 0-F hex decode. Tear-free updates: a new value takes effect only at a frame boundary.
// PARAMETERS
//   NUM_DIGITS   4     number of digits scanned, 1..8
//   REFRESH_DIV  1000  clk cycles per digit slot, >=2
//   CNT_W        10    prescaler width, must satisfy 2**CNT_W >= REFRESH_DIV
// PORTS
//   clk          in   1             single clock, rising edge
//   rst_n        in   1             asynchronous, active-low reset
//   value        in   4*NUM_DIGITS  nibble k = digit k, digit 0 = least significant
//   load         in   1             1-cycle strobe: capture value into pending register
//   blank        in   1             1 = all digit enables low
//   seg          out  7             {a,b,c,d,e,f,g}, active-high, bit6 = a
//   dig_en       out  NUM_DIGITS    one-hot active-high digit enable
//   frame_start  out  1             1-cycle pulse when the scan wraps to digit 0
// BEHAVIOUR
//   Reset (async assert, sync release): all registers are 0.
//     Registers: seg, dig_en, frame_start, prescaler, idx, disp_reg, pend_reg, pend_valid.
//   Prescaler counts 0..REFRESH_DIV-1, then wraps. tick = (prescaler == REFRESH_DIV-1).
//   On tick: idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1.
//   Wrap tick (tick and idx == NUM_DIGITS-1):
//     frame_start <= 1 for one cycle, otherwise 0.
//     If pend_valid: disp_reg <= pend_reg and pend_valid <= 0.
//   load: pend_reg <= value, pend_valid <= 1.
//     Multiple loads within one frame: the last one wins.
//   load on the same cycle as the wrap transfer:
//     - transfer uses the old pend_reg;
//     - the new value goes to pend_reg;
//     - pend_valid stays 1, so the new value takes effect at the next frame.
//   Outputs are registered, 1-cycle latency from idx/disp_reg/blank:
//     seg    <= decode(disp_reg[4*idx +: 4])
//     dig_en <= blank ? 0 : (1 << idx)
//   Decode is standard hex:
//     0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70
//     8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47
//   blank does not stop scanning, prescaler, or frame_start. seg still toggles while blanked.
//   NUM_DIGITS=1: idx stays 0; every tick is a wrap tick.
//   Reset mid-frame clears everything immediately, including any pending load.
// CONFIGURATION
//   SEVENSEG_LZB_EN defined: leading-zero blanking.
//     A digit k>0 drives dig_en low when nibbles k..NUM_DIGITS-1 of disp_reg are all 0.
//     Digit 0 is never suppressed, so value 0 shows a single "0".
//   SEVENSEG_LZB_EN undefined: every digit is always shown, including zeros.
// STRUCTURE
//   Package sevenseg_pkg:
//     - SEG_* constants for the 16 glyphs;
//     - SEG_BLANK = 7'h00;
//     - helper function onehot(idx).
//   Sub-module sevenseg_hex_decode (combinational, 4-bit in, 7-bit out, from package constants).
//     Instantiated once on the muxed nibble.
//   Top holds the prescaler, idx counter, pending/display registers and output registers.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=4 unless noted)
//   1 Reset: assert rst_n=0 mid-run.
//     -> seg=0, dig_en=0, frame_start=0 asynchronously.
//     -> After release, dig_en=4'b0001 and seg=7E (disp_reg=0) from cycle 1.
//   2 Scan: load value=16'h1A2F, run 2 frames.
//     -> Before the first wrap, display shows all-zero glyphs.
//     -> After the wrap: F(47), 2(6D), A(77), 1(30) on dig_en 0001/0010/0100/1000.
//     -> Each digit is held 4 cycles. frame_start pulses every 16 cycles.
//   3 Tear-free: load 16'h1111 mid-frame, then 16'h2222 in the same frame.
//     -> Rest of the frame shows the old value.
//     -> The next frame shows 2 (6D) on all digits. 1111 is never displayed.
//   4 Collision: load 16'h3333 on the exact wrap cycle while 16'h2222 is pending.
//     -> That frame shows 2222. The next frame shows 3333.
//   5 Blank: blank=1 for one frame.
//     -> dig_en=0 throughout; frame_start cadence is unchanged.
//     -> Release resumes on the current idx with no skip.
//   6 LZB (macro on): value 16'h0050.
//     -> Digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0.
//     -> value 0: only digit 0 lit, showing 7E.
//     -> Macro off: all 4 digits lit.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// -----------------------------------------------------------------------------
// sevenseg_pkg
//   Shared constants for the seven-segment scan driver.
//   - SEG_0 .. SEG_F : active-high glyphs, bit order {a,b,c,d,e,f,g}, bit6 = a
//   - SEG_BLANK      : all segments off
//   - onehot()       : digit index to one-hot enable (up to 8 digits)
// -----------------------------------------------------------------------------
package sevenseg_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int MAX_DIGITS = 8;

    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/sevenseg_if.sv
// -----------------------------------------------------------------------------
// sevenseg_if
//   Bundle between a value producer and the scan driver.
//   Producer side (master): value, load, blank
//   Driver side   (slave) : seg, dig_en, frame_start
//   value       : 4*NUM_DIGITS, nibble k = digit k, digit 0 least significant
//   load        : 1-cycle strobe, capture value into the pending register
//   blank       : 1 = all digit enables low
//   seg         : {a,b,c,d,e,f,g}, active-high
//   dig_en      : one-hot active-high digit enable
//   frame_start : 1-cycle pulse when the scan wraps to digit 0
// -----------------------------------------------------------------------------
interface sevenseg_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic                    blank;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic                    frame_start;

    modport master (
        output value, load, blank,
        input  seg, dig_en, frame_start
    );

    modport slave (
        input  value, load, blank,
        output seg, dig_en, frame_start
    );
endinterface

// File: rtl/sevenseg_hex_decode.sv
// -----------------------------------------------------------------------------
// sevenseg_hex_decode
//   Combinational 0-F hex to seven-segment glyph.
//   i_nib : 4-bit hex digit
//   o_seg : {a,b,c,d,e,f,g}, active-high
// -----------------------------------------------------------------------------
module sevenseg_hex_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nib)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_driver
//   Time-multiplexed driver for NUM_DIGITS common-segment 7-segment digits.
//   One digit is refreshed per REFRESH_DIV clock cycles. A loaded value waits in
//   a pending register and is copied to the display register only when the
//   scan wraps back to digit 0, so a frame never shows a mix of two values.
//
//   Ports:
//     clk     : rising-edge clock
//     rst_n   : asynchronous active-low reset
//     disp_if : sevenseg_if.slave (value/load/blank in, seg/dig_en/frame_start out)
//
//   Parameters:
//     NUM_DIGITS  : 1..8 digits
//     REFRESH_DIV : clk cycles per digit slot, >= 2
//     CNT_W       : prescaler width, 2**CNT_W >= REFRESH_DIV
//
//   Build option:
//     SEVENSEG_LZB_EN : when defined, leading-zero digits (k > 0) are kept dark.
// -----------------------------------------------------------------------------
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int CNT_W       = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    sevenseg_if.slave   disp_if
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      r_presc;
    logic [IDX_W-1:0]      r_idx;
    logic [VAL_W-1:0]      r_disp;
    logic [VAL_W-1:0]      r_pend;
    logic                  r_pend_vld;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_dig_en;
    logic                  r_frame_start;

    logic                  w_tick;
    logic                  w_last;
    logic                  w_wrap;
    logic [3:0]            w_nib;
    logic [6:0]            w_seg;
    logic [MAX_DIGITS-1:0] w_onehot;
    logic                  w_suppress;

    assign w_tick = (r_presc == CNT_W'(REFRESH_DIV - 1));
    assign w_last = (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_wrap = w_tick & w_last;

    assign w_nib    = r_disp[4*r_idx +: 4];
    assign w_onehot = onehot(3'(r_idx));

`ifdef SEVENSEG_LZB_EN
    // A digit above 0 is a leading zero when it and every higher nibble are 0.
    logic [VAL_W-1:0] w_upper;
    assign w_upper    = r_disp >> (4 * r_idx);
    assign w_suppress = (r_idx != '0) && (w_upper == '0);
`else
    assign w_suppress = 1'b0;
`endif

    sevenseg_hex_decode u_decode (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    // Slot timing: prescaler, digit index, frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc       <= '0;
            r_idx         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_presc       <= w_tick ? '0 : r_presc + CNT_W'(1);
            r_frame_start <= w_wrap;
            if (w_tick)
                r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
        end
    end

    // Pending/display registers. On a wrap that coincides with a load, the
    // transfer takes the old pending value and the new load stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp     <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            if (w_wrap && r_pend_vld) begin
                r_disp     <= r_pend;
                r_pend_vld <= 1'b0;
            end
            if (disp_if.load) begin
                r_pend     <= disp_if.value;
                r_pend_vld <= 1'b1;
            end
        end
    end

    // Registered outputs; blank gates enables only, scanning continues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg    <= '0;
            r_dig_en <= '0;
        end else begin
            r_seg    <= w_seg;
            r_dig_en <= (disp_if.blank || w_suppress) ? '0 : w_onehot[NUM_DIGITS-1:0];
        end
    end

    assign disp_if.seg         = r_seg;
    assign disp_if.dig_en      = r_dig_en;
    assign disp_if.frame_start = r_frame_start;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan_driver
//   Bench for sevenseg_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4.
//   Honours SEVENSEG_LZB_EN the same way as the design build.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan_driver;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int FRAME = ND * RD;

`ifdef SEVENSEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    sevenseg_if #(.NUM_DIGITS(ND)) bus ();

    sevenseg_scan_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .CNT_W       (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .disp_if (bus)
    );

    always #5 clk = ~clk;

    logic [6:0]  glyph [16];
    int          n_chk  = 0;
    int          n_pass = 0;

    // Reference state: cycles since reset release, displayed and pending values
    int          n;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_pv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    // One clock edge: predict outputs from the state before the edge, advance
    // the reference, then compare just after the edge.
    task automatic cycle();
        int          id;
        bit          wrap;
        logic [15:0] upper;
        logic [6:0]  e_seg;
        logic [3:0]  e_dig;
        id    = (n / RD) % ND;
        wrap  = (n % FRAME) == FRAME - 1;
        upper = m_disp >> (4 * id);
        e_seg = glyph[upper[3:0]];
        if (bus.blank || (LZB && id != 0 && upper == '0))
            e_dig = '0;
        else
            e_dig = 4'(1 << id);
        if (wrap && m_pv) begin
            m_disp = m_pend;
            m_pv   = 1'b0;
        end
        if (bus.load) begin
            m_pend = bus.value;
            m_pv   = 1'b1;
        end
        n++;
        @(posedge clk);
        #1;
        chk("seg", 32'(bus.seg), 32'(e_seg));
        chk("dig_en", 32'(bus.dig_en), 32'(e_dig));
        chk("frame_start", 32'(bus.frame_start), 32'(wrap));
    endtask

    task automatic run_to(input int k);
        while (n < k) cycle();
    endtask

    task automatic load_val(input logic [15:0] v);
        bus.value = v;
        bus.load  = 1'b1;
        cycle();
        bus.load  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #4;
        rst_n    = 1'b0;
        bus.load = 1'b0;
        bus.blank = 1'b0;
        #1;
        chk("rst_seg", 32'(bus.seg), 32'h0);
        chk("rst_dig_en", 32'(bus.dig_en), 32'h0);
        chk("rst_frame_start", 32'(bus.frame_start), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #5;
        rst_n  = 1'b1;
        n      = 0;
        m_disp = '0;
        m_pend = '0;
        m_pv   = 1'b0;
    endtask

    initial begin
        glyph = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        bus.value = '0;
        bus.load  = 1'b0;
        bus.blank = 1'b0;
        n = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;

        // Reset and first cycle after release
        do_reset();
        cycle();
        chk("rel_dig_en", 32'(bus.dig_en), 32'h1);
        chk("rel_seg", 32'(bus.seg), 32'h7E);

        // Scan of 1A2F
        load_val(16'h1A2F);
        run_to(16);
        chk("scan_fs0", 32'(bus.frame_start), 32'h1);
        run_to(17);
        chk("scan_d0_seg", 32'(bus.seg), 32'h47);
        chk("scan_d0_en", 32'(bus.dig_en), 32'h1);
        run_to(21);
        chk("scan_d1_seg", 32'(bus.seg), 32'h6D);
        chk("scan_d1_en", 32'(bus.dig_en), 32'h2);
        run_to(25);
        chk("scan_d2_seg", 32'(bus.seg), 32'h77);
        chk("scan_d2_en", 32'(bus.dig_en), 32'h4);
        run_to(29);
        chk("scan_d3_seg", 32'(bus.seg), 32'h30);
        chk("scan_d3_en", 32'(bus.dig_en), 32'h8);
        run_to(32);
        chk("scan_fs1", 32'(bus.frame_start), 32'h1);

        // Tear-free: two loads within one frame, last wins
        run_to(36);
        load_val(16'h1111);
        run_to(40);
        load_val(16'h2222);
        run_to(45);
        chk("tear_old", 32'(bus.seg), 32'h30);
        run_to(49);
        chk("tear_new", 32'(bus.seg), 32'h6D);

        // Collision: load on the exact wrap cycle while a value is pending
        run_to(52);
        load_val(16'h2222);
        run_to(63);
        load_val(16'h3333);
        run_to(65);
        chk("coll_first", 32'(bus.seg), 32'h6D);
        run_to(81);
        chk("coll_next", 32'(bus.seg), 32'h79);

        // Blank for one full frame
        run_to(96);
        bus.blank = 1'b1;
        run_to(100);
        chk("blank_en", 32'(bus.dig_en), 32'h0);
        chk("blank_seg", 32'(bus.seg), 32'h79);
        run_to(112);
        chk("blank_fs", 32'(bus.frame_start), 32'h1);
        bus.blank = 1'b0;
        run_to(113);
        chk("unblank_en", 32'(bus.dig_en), 32'h1);

        // Leading zeros: 0050 then 0000
        load_val(16'h0050);
        run_to(129);
        chk("lz_d0_seg", 32'(bus.seg), 32'h7E);
        chk("lz_d0_en", 32'(bus.dig_en), 32'h1);
        run_to(133);
        chk("lz_d1_seg", 32'(bus.seg), 32'h5B);
        chk("lz_d1_en", 32'(bus.dig_en), 32'h2);
        run_to(137);
        chk("lz_d2_en", 32'(bus.dig_en), LZB ? 32'h0 : 32'h4);
        run_to(141);
        chk("lz_d3_en", 32'(bus.dig_en), LZB ? 32'h0 : 32'h8);
        load_val(16'h0000);
        run_to(145);
        chk("zero_d0_seg", 32'(bus.seg), 32'h7E);
        chk("zero_d0_en", 32'(bus.dig_en), 32'h1);
        run_to(149);
        chk("zero_d1_en", 32'(bus.dig_en), LZB ? 32'h0 : 32'h2);

        // Randomized loads and blanking
        for (int i = 0; i < 400; i++) begin
            bus.load  = ($urandom_range(0, 7) == 0);
            bus.value = 16'($urandom);
            if ($urandom_range(0, 9) == 0)
                bus.blank = ~bus.blank;
            cycle();
        end
        bus.load  = 1'b0;
        bus.blank = 1'b0;
        run_to(n + 3);

        // Reset mid-frame drops a pending load
        load_val(16'hABCD);
        do_reset();
        cycle();
        chk("rst2_dig_en", 32'(bus.dig_en), 32'h1);
        chk("rst2_seg", 32'(bus.seg), 32'h7E);
        run_to(17);
        chk("rst2_no_pend", 32'(bus.seg), 32'h7E);
        run_to(40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
